// File: rtl/audio_asrc_pkg.sv
// Shared types for the audio FIR time-division path: issue FSM states,
// default sample widths and the stereo frame layout.
package audio_asrc_pkg;

  localparam int unsigned DW_IN_DEF  = 16;
  localparam int unsigned DW_OUT_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_L = 3'd1,
    ST_HOLD_L = 3'd2,
    ST_SEND_R = 3'd3,
    ST_HOLD_R = 3'd4
  } issue_state_e;

  typedef struct packed {
    logic [DW_IN_DEF-1:0] left;
    logic [DW_IN_DEF-1:0] right;
  } stereo_frame_t;

endpackage

// File: rtl/frame_fifo2.sv
// Two-entry stereo frame FIFO. A write while full is dropped unless a read
// frees the head entry in the same cycle.
module frame_fifo2
  import audio_asrc_pkg::*;
#(
  parameter type T = stereo_frame_t
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_wr,
  input  T     i_wdata,
  input  logic i_rd,
  output T     o_rdata,
  output logic o_full,
  output logic o_empty
);

  T           r_mem0;
  T           r_mem1;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_rdata = r_mem0;
  assign w_pop   = i_rd && !o_empty;
  assign w_push  = i_wr && (!o_full || i_rd);

  // r_mem0 is always the head, so a pop shifts the second entry forward.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem0  <= '0;
      r_mem1  <= '0;
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_mem0 <= i_wdata;
          else                 r_mem1 <= i_wdata;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_mem0  <= r_mem1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_mem0 <= i_wdata;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fir_tdm_scheduler.sv
// Shares one FIR between left/right: buffers stereo frames, issues sop/eop
// beat pairs at a throttled rate and reassembles the returned beats.
module fir_tdm_scheduler
  import audio_asrc_pkg::*;
#(
  parameter int unsigned DW_IN     = DW_IN_DEF,
  parameter int unsigned DW_OUT    = DW_OUT_DEF,
  parameter int unsigned GAP       = 2,
  parameter int unsigned SHIFT     = 4,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic              AMCLK_i,
  input  logic              ARST,
  input  logic [DW_IN-1:0]  APDATA_LEFT_i,
  input  logic [DW_IN-1:0]  APDATA_RIGHT_i,
  input  logic              APDATA_VALID_i,
  output logic [DW_IN-1:0]  ast_sink_data,
  output logic              ast_sink_valid,
  output logic              ast_sink_sop,
  output logic              ast_sink_eop,
  input  logic [DW_OUT-1:0] ast_source_data,
  input  logic              ast_source_valid,
  input  logic              ast_source_sop,
  input  logic              ast_source_eop,
  output logic [DW_OUT-1:0] APDATA_INT_LEFT_o,
  output logic [DW_OUT-1:0] APDATA_INT_RIGHT_o,
  output logic              APDATA_INT_VALID_o,
  output logic              OVF_o,
  output logic              SEQERR_o
);

  typedef struct packed {
    logic [DW_IN-1:0] left;
    logic [DW_IN-1:0] right;
  } frame_t;

  localparam logic [1:0] OUTST_LIM = 2'(MAX_OUTST);
  localparam logic [3:0] HOLD_CYC  = 4'(GAP - 1);

  issue_state_e      r_state;
  issue_state_e      w_next;
  logic [3:0]        r_gap;
  logic [1:0]        r_outst;
  logic              r_got_l;
  logic [DW_OUT-1:0] r_left_hold;
  frame_t            w_wdata;
  frame_t            w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_dec;
  logic              w_drop;
  logic              w_can_issue;
  logic [DW_OUT-1:0] w_src_shifted;

  assign w_wdata       = {APDATA_LEFT_i, APDATA_RIGHT_i};
  assign w_drop        = APDATA_VALID_i && w_full && !w_pop;
  assign w_can_issue   = !w_empty && (r_outst < OUTST_LIM);
  assign w_pop         = (w_next == ST_SEND_R);
  assign w_dec         = ast_source_valid && ast_source_eop;
  assign w_src_shifted = ast_source_data << SHIFT;

  frame_fifo2 #(.T(frame_t)) u_fifo (
    .i_clk   (AMCLK_i),
    .i_rst   (ARST),
    .i_wr    (APDATA_VALID_i),
    .i_wdata (w_wdata),
    .i_rd    (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The last hold-R cycle decides directly, so IDLE costs no extra cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_can_issue) w_next = ST_SEND_L;
      ST_SEND_L: w_next = (GAP == 1) ? ST_SEND_R : ST_HOLD_L;
      ST_HOLD_L: if (r_gap == 4'd1) w_next = ST_SEND_R;
      ST_SEND_R: begin
        if (GAP == 1) w_next = w_can_issue ? ST_SEND_L : ST_IDLE;
        else          w_next = ST_HOLD_R;
      end
      ST_HOLD_R: if (r_gap == 4'd1) w_next = w_can_issue ? ST_SEND_L : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Sink qualifiers are registered from the next state; the pop and outst
  // increment land on the same edge that presents the right-channel beat.
  always_ff @(posedge AMCLK_i) begin
    if (ARST) begin
      r_state        <= ST_IDLE;
      r_gap          <= '0;
      r_outst        <= '0;
      ast_sink_data  <= '0;
      ast_sink_valid <= 1'b0;
      ast_sink_sop   <= 1'b0;
      ast_sink_eop   <= 1'b0;
    end else begin
      r_state        <= w_next;
      ast_sink_valid <= (w_next == ST_SEND_L) || (w_next == ST_SEND_R);
      ast_sink_sop   <= (w_next == ST_SEND_L);
      ast_sink_eop   <= (w_next == ST_SEND_R);
      if (w_next == ST_SEND_L)      ast_sink_data <= w_head.left;
      else if (w_next == ST_SEND_R) ast_sink_data <= w_head.right;
      if ((w_next == ST_SEND_L) || (w_next == ST_SEND_R))
        r_gap <= HOLD_CYC;
      else if ((r_state == ST_HOLD_L) || (r_state == ST_HOLD_R))
        r_gap <= r_gap - 4'd1;
      case ({w_pop, w_dec})
        2'b10:   r_outst <= r_outst + 2'd1;
        2'b01:   if (r_outst != 2'd0) r_outst <= r_outst - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge AMCLK_i) begin
    if (ARST) begin
      r_got_l            <= 1'b0;
      r_left_hold        <= '0;
      APDATA_INT_LEFT_o  <= '0;
      APDATA_INT_RIGHT_o <= '0;
      APDATA_INT_VALID_o <= 1'b0;
      OVF_o              <= 1'b0;
      SEQERR_o           <= 1'b0;
    end else begin
      APDATA_INT_VALID_o <= 1'b0;
      if (w_drop) OVF_o <= 1'b1;
      if (ast_source_valid) begin
        if (ast_source_sop && ast_source_eop) begin
          SEQERR_o <= 1'b1;
        end else if (ast_source_sop) begin
          if (r_got_l) SEQERR_o <= 1'b1;
          r_left_hold <= w_src_shifted;
          r_got_l     <= 1'b1;
        end else if (ast_source_eop) begin
          if (r_got_l) begin
            APDATA_INT_LEFT_o  <= r_left_hold;
            APDATA_INT_RIGHT_o <= w_src_shifted;
            APDATA_INT_VALID_o <= 1'b1;
            r_got_l            <= 1'b0;
          end else begin
            SEQERR_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// Directed bench for fir_tdm_scheduler (GAP=2, SHIFT=4, MAX_OUTST=2) plus a
// randomised run against a fixed-latency FIR loopback model.
module tb_fir_tdm_scheduler;

  logic        AMCLK_i = 1'b0;
  logic        ARST = 1'b1;
  logic [15:0] APDATA_LEFT_i = '0;
  logic [15:0] APDATA_RIGHT_i = '0;
  logic        APDATA_VALID_i = 1'b0;
  logic [15:0] ast_sink_data;
  logic        ast_sink_valid;
  logic        ast_sink_sop;
  logic        ast_sink_eop;
  logic [23:0] ast_source_data = '0;
  logic        ast_source_valid = 1'b0;
  logic        ast_source_sop = 1'b0;
  logic        ast_source_eop = 1'b0;
  logic [23:0] APDATA_INT_LEFT_o;
  logic [23:0] APDATA_INT_RIGHT_o;
  logic        APDATA_INT_VALID_o;
  logic        OVF_o;
  logic        SEQERR_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic        dl_v [8];
  logic        dl_s [8];
  logic        dl_e [8];
  logic [15:0] dl_d [8];
  logic [31:0] exp_q [$];

  fir_tdm_scheduler #(
    .DW_IN(16), .DW_OUT(24), .GAP(2), .SHIFT(4), .MAX_OUTST(2)
  ) dut (
    .AMCLK_i            (AMCLK_i),
    .ARST               (ARST),
    .APDATA_LEFT_i      (APDATA_LEFT_i),
    .APDATA_RIGHT_i     (APDATA_RIGHT_i),
    .APDATA_VALID_i     (APDATA_VALID_i),
    .ast_sink_data      (ast_sink_data),
    .ast_sink_valid     (ast_sink_valid),
    .ast_sink_sop       (ast_sink_sop),
    .ast_sink_eop       (ast_sink_eop),
    .ast_source_data    (ast_source_data),
    .ast_source_valid   (ast_source_valid),
    .ast_source_sop     (ast_source_sop),
    .ast_source_eop     (ast_source_eop),
    .APDATA_INT_LEFT_o  (APDATA_INT_LEFT_o),
    .APDATA_INT_RIGHT_o (APDATA_INT_RIGHT_o),
    .APDATA_INT_VALID_o (APDATA_INT_VALID_o),
    .OVF_o              (OVF_o),
    .SEQERR_o           (SEQERR_o)
  );

  always #5 AMCLK_i = ~AMCLK_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge AMCLK_i);
    #1;
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    APDATA_LEFT_i  = l;
    APDATA_RIGHT_i = r;
    APDATA_VALID_i = 1'b1;
    tick();
    APDATA_VALID_i = 1'b0;
  endtask

  task automatic src(input logic s, input logic e, input logic [23:0] d);
    ast_source_data  = d;
    ast_source_sop   = s;
    ast_source_eop   = e;
    ast_source_valid = 1'b1;
    tick();
    ast_source_valid = 1'b0;
    ast_source_sop   = 1'b0;
    ast_source_eop   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sink"}, {ast_sink_valid, ast_sink_sop, ast_sink_eop, ast_sink_data}, 32'h0);
    check({tag, "_outl"}, {APDATA_INT_VALID_o, APDATA_INT_LEFT_o}, 32'h0);
    check({tag, "_outr"}, APDATA_INT_RIGHT_o, 32'h0);
    check({tag, "_flags"}, {OVF_o, SEQERR_o}, 32'h0);
  endtask

  initial begin
    logic seen;
    int   wait_cnt;
    int   sent;
    int   got_frames;
    logic [15:0] rl;
    logic [15:0] rr;
    logic [31:0] ef;

    tick();
    tick();
    check_all_zero("reset");
    ARST = 1'b0;

    // Single frame: sop at t+1, eop at t+1+GAP, loopback reassembly.
    strobe(16'h1234, 16'hABCD);
    check("t1_t0_nobeat", ast_sink_valid, 32'd0);
    tick();
    check("t1_sop_beat", {ast_sink_valid, ast_sink_sop, ast_sink_eop, ast_sink_data}, {13'd0, 3'b110, 16'h1234});
    tick();
    check("t1_gap_hold", {ast_sink_valid, ast_sink_data}, {15'd0, 1'b0, 16'h1234});
    tick();
    check("t1_eop_beat", {ast_sink_valid, ast_sink_sop, ast_sink_eop, ast_sink_data}, {13'd0, 3'b101, 16'hABCD});
    tick();
    check("t1_after", {ast_sink_valid, ast_sink_data}, {15'd0, 1'b0, 16'hABCD});
    src(1'b1, 1'b0, 24'h000123);
    check("t1_no_pulse_sop", APDATA_INT_VALID_o, 32'd0);
    src(1'b0, 1'b1, 24'h000ABC);
    check("t1_pulse", APDATA_INT_VALID_o, 32'd1);
    check("t1_left", APDATA_INT_LEFT_o, 32'h001230);
    check("t1_right", APDATA_INT_RIGHT_o, 32'h00ABC0);
    tick();
    check("t1_pulse_end", APDATA_INT_VALID_o, 32'd0);
    check("t1_left_hold", APDATA_INT_LEFT_o, 32'h001230);

    // Truncation after shift: top nibble falls off.
    strobe(16'h0001, 16'h0002);
    repeat (4) tick();
    src(1'b1, 1'b0, 24'hF12345);
    src(1'b0, 1'b1, 24'h800001);
    check("trunc_left", APDATA_INT_LEFT_o, 32'h123450);
    check("trunc_right", APDATA_INT_RIGHT_o, 32'h000010);

    // FIFO overflow, write-while-full-with-pop, outstanding limit.
    strobe(16'h1111, 16'h2222);
    strobe(16'h3333, 16'h4444);
    check("t2_no_ovf_yet", OVF_o, 32'd0);
    strobe(16'h5555, 16'h6666);
    check("t2_ovf", OVF_o, 32'd1);
    strobe(16'h7777, 16'h8888);
    check("t2_a_eop", {ast_sink_valid, ast_sink_eop, ast_sink_data}, {14'd0, 2'b11, 16'h2222});
    tick();
    tick();
    check("t2_b_sop", {ast_sink_valid, ast_sink_sop, ast_sink_data}, {14'd0, 2'b11, 16'h3333});
    tick();
    tick();
    check("t2_b_eop", {ast_sink_valid, ast_sink_eop, ast_sink_data}, {14'd0, 2'b11, 16'h4444});
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen = seen | ast_sink_valid;
    end
    check("t2_outst_block", seen, 32'd0);
    src(1'b1, 1'b0, 24'h001111);
    src(1'b0, 1'b1, 24'h002222);
    check("t2_a_out", {APDATA_INT_VALID_o, APDATA_INT_LEFT_o}, {7'd0, 1'b1, 24'h011110});
    check("t2_a_outr", APDATA_INT_RIGHT_o, 32'h022220);
    check("t2_wait_dec", ast_sink_valid, 32'd0);
    tick();
    check("t2_d_sop", {ast_sink_valid, ast_sink_sop, ast_sink_data}, {14'd0, 2'b11, 16'h7777});
    tick();
    tick();
    check("t2_d_eop", {ast_sink_valid, ast_sink_eop, ast_sink_data}, {14'd0, 2'b11, 16'h8888});
    src(1'b1, 1'b0, 24'h003333);
    src(1'b0, 1'b1, 24'h004444);
    check("t2_b_outl", APDATA_INT_LEFT_o, 32'h033330);
    check("t2_b_outr", APDATA_INT_RIGHT_o, 32'h044440);
    src(1'b1, 1'b0, 24'h007777);
    src(1'b0, 1'b1, 24'h008888);
    check("t2_d_outl", APDATA_INT_LEFT_o, 32'h077770);

    // Source framing errors.
    src(1'b0, 1'b1, 24'h000999);
    check("t3_seqerr", SEQERR_o, 32'd1);
    check("t3_no_pulse", APDATA_INT_VALID_o, 32'd0);
    check("t3_hold_l", APDATA_INT_LEFT_o, 32'h077770);
    check("t3_hold_r", APDATA_INT_RIGHT_o, 32'h088880);
    src(1'b1, 1'b1, 24'h000555);
    check("t3_sopeop_drop", {APDATA_INT_VALID_o, APDATA_INT_RIGHT_o}, {7'd0, 1'b0, 24'h088880});
    src(1'b1, 1'b0, 24'h000AAA);
    src(1'b1, 1'b0, 24'h000BBB);
    src(1'b0, 1'b1, 24'h000CCC);
    check("t3_restart_l", {APDATA_INT_VALID_o, APDATA_INT_LEFT_o}, {7'd0, 1'b1, 24'h00BBB0});
    check("t3_restart_r", APDATA_INT_RIGHT_o, 32'h00CCC0);
    check("t3_sticky", {OVF_o, SEQERR_o}, 32'd3);

    // Reset between SEND_L and SEND_R.
    ARST = 1'b1;
    tick();
    ARST = 1'b0;
    check_all_zero("t4_rst");
    strobe(16'h0101, 16'h0202);
    tick();
    check("t4_sop", {ast_sink_valid, ast_sink_sop, ast_sink_data}, {14'd0, 2'b11, 16'h0101});
    ARST = 1'b1;
    tick();
    ARST = 1'b0;
    check_all_zero("t4_mid");
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen = seen | ast_sink_valid;
    end
    check("t4_no_beat", seen, 32'd0);
    src(1'b0, 1'b1, 24'h000321);
    check("t4_stray", {OVF_o, SEQERR_o, APDATA_INT_VALID_o}, 32'b010);
    check("t4_out_zero", APDATA_INT_LEFT_o, 32'h0);

    // Random traffic through a fixed-latency loopback FIR model.
    ARST = 1'b1;
    tick();
    ARST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dl_v[i] = 1'b0; dl_s[i] = 1'b0; dl_e[i] = 1'b0; dl_d[i] = '0;
    end
    wait_cnt   = 3;
    sent       = 0;
    got_frames = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (sent == 30 && exp_q.size() == 0) break;
      APDATA_VALID_i = 1'b0;
      if (sent < 30) begin
        if (wait_cnt == 0) begin
          rl = 16'($urandom);
          rr = 16'($urandom);
          APDATA_LEFT_i  = rl;
          APDATA_RIGHT_i = rr;
          APDATA_VALID_i = 1'b1;
          exp_q.push_back({rl, rr});
          sent++;
          wait_cnt = $urandom_range(6, 11);
        end else begin
          wait_cnt--;
        end
      end
      ast_source_valid = dl_v[6];
      ast_source_sop   = dl_s[6];
      ast_source_eop   = dl_e[6];
      ast_source_data  = {dl_d[6][7:0], dl_d[6]};
      tick();
      for (int i = 7; i > 0; i--) begin
        dl_v[i] = dl_v[i-1]; dl_s[i] = dl_s[i-1]; dl_e[i] = dl_e[i-1]; dl_d[i] = dl_d[i-1];
      end
      dl_v[0] = ast_sink_valid;
      dl_s[0] = ast_sink_sop;
      dl_e[0] = ast_sink_eop;
      dl_d[0] = ast_sink_data;
      if (APDATA_INT_VALID_o) begin
        if (exp_q.size() == 0) begin
          check("rnd_extra_frame", 32'd1, 32'd0);
        end else begin
          ef = exp_q.pop_front();
          got_frames++;
          check("rnd_left", APDATA_INT_LEFT_o, {8'd0, ef[19:16], ef[31:16], 4'h0});
          check("rnd_right", APDATA_INT_RIGHT_o, {8'd0, ef[3:0], ef[15:0], 4'h0});
        end
      end
    end
    APDATA_VALID_i   = 1'b0;
    ast_source_valid = 1'b0;
    check("rnd_drained", exp_q.size(), 32'd0);
    check("rnd_frames", got_frames, 32'd30);
    check("rnd_flags", {OVF_o, SEQERR_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
